voice_scheduler: RTL and testbench

VOICE_SCHEDULER -- requirements
Module: voice_scheduler

---
 rtl/voice_scheduler_if.sv | 24 ++
 rtl/voice_scheduler.sv | 142 ++++++++++++++
 tb/tb_voice_scheduler.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/voice_scheduler_if.sv
// Command and voice-output bundle between the CPU command FIFO and the voice scheduler.
interface voice_scheduler_if #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned PERIOD_W   = 23
);
  logic                           cmd_valid;
  logic [31:0]                    cmd_data;
  logic                           cmd_ready;
  logic [NUM_VOICES*PERIOD_W-1:0] voice_period;
  logic [NUM_VOICES-1:0]          voice_on;
  logic [NUM_VOICES-1:0]          voice_off;
  logic [NUM_VOICES-1:0]          voice_active;
  logic [7:0]                     steal_cnt;

  modport master (
    output cmd_valid, cmd_data,
    input  cmd_ready, voice_period, voice_on, voice_off, voice_active, steal_cnt
  );

  modport slave (
    input  cmd_valid, cmd_data,
    output cmd_ready, voice_period, voice_on, voice_off, voice_active, steal_cnt
  );
endinterface

// File: rtl/voice_scheduler.sv
// Four-voice note allocator: retrigger on id match, else lowest free voice, else steal the oldest.
// Each command takes IDLE -> SEARCH -> COMMIT; results are registered at the end of SEARCH.
module voice_scheduler (
  input  logic               clk,
  input  logic               rst,
  voice_scheduler_if.slave   bus
);
  localparam int unsigned NUM_VOICES = 4;
  localparam int unsigned PERIOD_W   = 23;
  localparam int unsigned ID_W       = 7;
  localparam int unsigned IDX_W      = 2;
  localparam int unsigned RANK_W     = 2;
  localparam int unsigned CNT_W      = 8;

  localparam logic [1:0] OP_NOTE_OFF = 2'b00;
  localparam logic [1:0] OP_NOTE_ON  = 2'b01;
  localparam logic [1:0] OP_ALL_OFF  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_COMMIT} state_t;

  state_t                r_state, w_next;
  logic [1:0]            r_op;
  logic [ID_W-1:0]       r_id;
  logic [PERIOD_W-1:0]   r_period;
  logic [ID_W-1:0]       r_ids     [NUM_VOICES];
  logic [PERIOD_W-1:0]   r_periods [NUM_VOICES];
  logic [RANK_W-1:0]     r_rank    [NUM_VOICES];
  logic [NUM_VOICES-1:0] r_active, r_on, r_off;
  logic [CNT_W-1:0]      r_steal;

  logic                  w_accept;
  logic                  w_match_hit, w_free_hit;
  logic [IDX_W-1:0]      w_match_idx, w_free_idx, w_oldest_idx, w_target;
  logic [RANK_W-1:0]     w_old_rank;
  logic                  w_is_on, w_is_off, w_steal;

  assign w_accept = bus.cmd_valid && (r_state == S_IDLE) && !rst;

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_SEARCH;
      S_SEARCH: w_next = S_COMMIT;
      S_COMMIT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Id match, lowest free voice and oldest (rank 3) voice
  always_comb begin
    w_match_hit  = 1'b0;
    w_match_idx  = '0;
    w_free_hit   = 1'b0;
    w_free_idx   = '0;
    w_oldest_idx = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      if (!w_match_hit && r_active[v] && (r_ids[v] == r_id)) begin
        w_match_hit = 1'b1;
        w_match_idx = IDX_W'(v);
      end
      if (!w_free_hit && !r_active[v]) begin
        w_free_hit = 1'b1;
        w_free_idx = IDX_W'(v);
      end
      if (r_rank[v] == '1) w_oldest_idx = IDX_W'(v);
    end
  end

  // A zero-period NOTE_ON is a NOTE_OFF for the same id
  always_comb begin
    w_is_on  = (r_op == OP_NOTE_ON) && (r_period != '0);
    w_is_off = (r_op == OP_NOTE_OFF) || ((r_op == OP_NOTE_ON) && (r_period == '0));
    w_steal  = w_is_on && !w_match_hit && !w_free_hit;
    if (w_match_hit)     w_target = w_match_idx;
    else if (w_free_hit) w_target = w_free_idx;
    else                 w_target = w_oldest_idx;
    w_old_rank = r_rank[w_target];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= '0;
      r_id     <= '0;
      r_period <= '0;
      r_active <= '0;
      r_on     <= '0;
      r_off    <= '0;
      r_steal  <= '0;
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        r_ids[v]     <= '0;
        r_periods[v] <= '0;
        r_rank[v]    <= RANK_W'(v);
      end
    end else begin
      r_on  <= '0;
      r_off <= '0;
      if (w_accept) begin
        r_op     <= bus.cmd_data[31:30];
        r_id     <= bus.cmd_data[29:23];
        r_period <= bus.cmd_data[22:0];
      end
      if (r_state == S_SEARCH) begin
        if (w_is_on) begin
          r_ids[w_target]     <= r_id;
          r_periods[w_target] <= r_period;
          r_active[w_target]  <= 1'b1;
          r_on[w_target]      <= 1'b1;
          for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            if (IDX_W'(v) == w_target)     r_rank[v] <= '0;
            else if (r_rank[v] < w_old_rank) r_rank[v] <= r_rank[v] + RANK_W'(1);
          end
          if (w_steal && (r_steal != '1)) r_steal <= r_steal + CNT_W'(1);
        end else if (w_is_off && w_match_hit) begin
          r_active[w_match_idx] <= 1'b0;
          r_off[w_match_idx]    <= 1'b1;
        end else if (r_op == OP_ALL_OFF) begin
          r_off    <= r_active;
          r_active <= '0;
        end
      end
    end
  end

  // Pulses are masked during rst so an aborted command never shows a pulse
  always_comb begin
    bus.voice_period = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++)
      bus.voice_period[v*PERIOD_W +: PERIOD_W] = r_periods[v];
  end

  assign bus.cmd_ready    = (r_state == S_IDLE) && !rst;
  assign bus.voice_on     = r_on  & ~{NUM_VOICES{rst}};
  assign bus.voice_off    = r_off & ~{NUM_VOICES{rst}};
  assign bus.voice_active = r_active;
  assign bus.steal_cnt    = r_steal;
endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler: allocation, retrigger, steal, note-off, all-off and reset abort.
module tb_voice_scheduler;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  voice_scheduler_if bus ();

  voice_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [1:0] OFF = 2'b00;
  localparam logic [1:0] ON  = 2'b01;
  localparam logic [1:0] ALL = 2'b10;
  localparam logic [1:0] RSV = 2'b11;

  function automatic logic [22:0] per(input int v);
    return bus.voice_period[v*23 +: 23];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Present one command in IDLE and stop in its COMMIT cycle
  task automatic issue(input logic [1:0] op, input logic [6:0] id, input logic [22:0] p);
    bus.cmd_data  = {op, id, p};
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    step();
  endtask

  task automatic issue_full(input logic [1:0] op, input logic [6:0] id, input logic [22:0] p);
    issue(op, id, p);
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = {ON, 7'd3, 23'd55};
    #1;
    n_cmp++; if (bus.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready_in_rst: got %b want 0", bus.cmd_ready); end
    step();
    step();
    n_cmp++; if ({bus.voice_on, bus.voice_off, bus.voice_active, bus.steal_cnt} !== 20'h0) begin n_bad++;
      $display("FAIL reset_outputs: on=%b off=%b act=%b steal=%0d want zeros", bus.voice_on, bus.voice_off, bus.voice_active, bus.steal_cnt); end
    n_cmp++; if (bus.voice_period !== 92'h0) begin n_bad++; $display("FAIL reset_period: got %h want 0", bus.voice_period); end
    rst = 1'b0;
    bus.cmd_valid = 1'b0;
    #1;
    n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready_after: got %b want 1", bus.cmd_ready); end
    step(); step(); step();
    n_cmp++; if (bus.voice_active !== 4'b0000) begin n_bad++; $display("FAIL reset_cmd_ignored: act=%b want 0000", bus.voice_active); end
  endtask

  task automatic test_first_note();
    do_reset();
    bus.cmd_data  = {ON, 7'd5, 23'd1000};
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    n_cmp++; if (bus.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL first_ready_search: got %b want 0", bus.cmd_ready); end
    n_cmp++; if (bus.voice_on !== 4'b0000) begin n_bad++; $display("FAIL first_on_early: got %b want 0000", bus.voice_on); end
    step();
    n_cmp++; if (bus.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL first_ready_commit: got %b want 0", bus.cmd_ready); end
    n_cmp++; if (bus.voice_on !== 4'b0001) begin n_bad++; $display("FAIL first_on: got %b want 0001", bus.voice_on); end
    n_cmp++; if (per(0) !== 23'd1000) begin n_bad++; $display("FAIL first_period: got %0d want 1000", per(0)); end
    n_cmp++; if (bus.voice_active !== 4'b0001) begin n_bad++; $display("FAIL first_active: got %b want 0001", bus.voice_active); end
    step();
    n_cmp++; if (bus.voice_on !== 4'b0000) begin n_bad++; $display("FAIL first_on_clear: got %b want 0000", bus.voice_on); end
    n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL first_ready_idle: got %b want 1", bus.cmd_ready); end
  endtask

  task automatic test_steal();
    do_reset();
    issue_full(ON, 7'd1, 23'd10);
    issue_full(ON, 7'd2, 23'd20);
    issue_full(ON, 7'd3, 23'd30);
    issue(ON, 7'd4, 23'd40);
    n_cmp++; if (bus.voice_on !== 4'b1000) begin n_bad++; $display("FAIL fill_on: got %b want 1000", bus.voice_on); end
    step();
    issue(ON, 7'd9, 23'd77);
    n_cmp++; if (bus.voice_on !== 4'b0001) begin n_bad++; $display("FAIL steal_on: got %b want 0001", bus.voice_on); end
    n_cmp++; if (bus.voice_off !== 4'b0000) begin n_bad++; $display("FAIL steal_off: got %b want 0000", bus.voice_off); end
    n_cmp++; if (bus.voice_period !== {23'd40, 23'd30, 23'd20, 23'd77}) begin n_bad++; $display("FAIL steal_period: got %h", bus.voice_period); end
    n_cmp++; if (bus.steal_cnt !== 8'd1) begin n_bad++; $display("FAIL steal_cnt: got %0d want 1", bus.steal_cnt); end
    n_cmp++; if (bus.voice_active !== 4'b1111) begin n_bad++; $display("FAIL steal_active: got %b want 1111", bus.voice_active); end
    step();
    // Ranks now v0=0,v1=3,v2=2,v3=1: next steal takes voice 1
    issue(ON, 7'd11, 23'd88);
    n_cmp++; if (bus.voice_on !== 4'b0010) begin n_bad++; $display("FAIL steal2_on: got %b want 0010", bus.voice_on); end
    step();
  endtask

  task automatic test_retrigger();
    do_reset();
    issue_full(ON, 7'd7, 23'd500);
    issue(ON, 7'd7, 23'd250);
    n_cmp++; if (bus.voice_on !== 4'b0001) begin n_bad++; $display("FAIL retrig_on: got %b want 0001", bus.voice_on); end
    n_cmp++; if (per(0) !== 23'd250) begin n_bad++; $display("FAIL retrig_period: got %0d want 250", per(0)); end
    n_cmp++; if (bus.voice_active !== 4'b0001) begin n_bad++; $display("FAIL retrig_active: got %b want 0001", bus.voice_active); end
    n_cmp++; if (bus.steal_cnt !== 8'd0) begin n_bad++; $display("FAIL retrig_steal: got %0d want 0", bus.steal_cnt); end
    step();
  endtask

  task automatic test_all_off();
    do_reset();
    issue_full(ON, 7'd1, 23'd11);
    issue_full(ON, 7'd2, 23'd22);
    issue_full(ON, 7'd3, 23'd33);
    issue(OFF, 7'd2, 23'd0);
    n_cmp++; if (bus.voice_off !== 4'b0010) begin n_bad++; $display("FAIL off_pulse: got %b want 0010", bus.voice_off); end
    n_cmp++; if (bus.voice_active !== 4'b0101) begin n_bad++; $display("FAIL off_active: got %b want 0101", bus.voice_active); end
    n_cmp++; if (per(1) !== 23'd22) begin n_bad++; $display("FAIL off_period_kept: got %0d want 22", per(1)); end
    step();
    issue(ALL, 7'd0, 23'd0);
    n_cmp++; if (bus.voice_off !== 4'b0101) begin n_bad++; $display("FAIL alloff_pulse: got %b want 0101", bus.voice_off); end
    n_cmp++; if (bus.voice_active !== 4'b0000) begin n_bad++; $display("FAIL alloff_active: got %b want 0000", bus.voice_active); end
    n_cmp++; if (bus.voice_on !== 4'b0000) begin n_bad++; $display("FAIL alloff_on: got %b want 0000", bus.voice_on); end
    step();
    n_cmp++; if (bus.voice_off !== 4'b0000) begin n_bad++; $display("FAIL alloff_clear: got %b want 0000", bus.voice_off); end
    issue(OFF, 7'd3, 23'd0);
    n_cmp++; if ({bus.voice_on, bus.voice_off, bus.voice_active} !== 12'h0) begin n_bad++;
      $display("FAIL off_unknown: on=%b off=%b act=%b want 0", bus.voice_on, bus.voice_off, bus.voice_active); end
    step();
  endtask

  task automatic test_zero_period();
    do_reset();
    issue_full(ON, 7'd8, 23'd55);
    issue_full(ON, 7'd4, 23'd66);
    issue(ON, 7'd4, 23'd0);
    n_cmp++; if (bus.voice_off !== 4'b0010) begin n_bad++; $display("FAIL zero_off: got %b want 0010", bus.voice_off); end
    n_cmp++; if (bus.voice_on !== 4'b0000) begin n_bad++; $display("FAIL zero_on: got %b want 0000", bus.voice_on); end
    n_cmp++; if (bus.voice_active !== 4'b0001) begin n_bad++; $display("FAIL zero_active: got %b want 0001", bus.voice_active); end
    n_cmp++; if (per(1) !== 23'd66) begin n_bad++; $display("FAIL zero_period_kept: got %0d want 66", per(1)); end
    step();
    issue(RSV, 7'd8, 23'd99);
    n_cmp++; if ({bus.voice_on, bus.voice_off, bus.voice_active} !== 12'h001) begin n_bad++;
      $display("FAIL reserved_op: on=%b off=%b act=%b want 0000/0000/0001", bus.voice_on, bus.voice_off, bus.voice_active); end
    n_cmp++; if (per(0) !== 23'd55) begin n_bad++; $display("FAIL reserved_period: got %0d want 55", per(0)); end
    step();
    issue(ON, 7'd10, 23'd12);
    n_cmp++; if (bus.voice_on !== 4'b0010) begin n_bad++; $display("FAIL reuse_free: got %b want 0010", bus.voice_on); end
    step();
  endtask

  task automatic test_abort();
    do_reset();
    issue_full(ON, 7'd1, 23'd5);
    bus.cmd_data  = {ON, 7'd2, 23'd9};
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.voice_on !== 4'b0000) begin n_bad++; $display("FAIL abort_search_on: got %b want 0000", bus.voice_on); end
    step();
    rst = 1'b0;
    #1;
    n_cmp++; if ({bus.voice_on, bus.voice_off, bus.voice_active, bus.steal_cnt} !== 20'h0) begin n_bad++;
      $display("FAIL abort_search_out: on=%b off=%b act=%b steal=%0d want zeros", bus.voice_on, bus.voice_off, bus.voice_active, bus.steal_cnt); end
    n_cmp++; if (bus.voice_period !== 92'h0) begin n_bad++; $display("FAIL abort_search_period: got %h want 0", bus.voice_period); end
    n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL abort_search_ready: got %b want 1", bus.cmd_ready); end
    step();
    n_cmp++; if (bus.voice_on !== 4'b0000) begin n_bad++; $display("FAIL abort_search_later: got %b want 0000", bus.voice_on); end
    issue(ON, 7'd3, 23'd17);
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.voice_on !== 4'b0000) begin n_bad++; $display("FAIL abort_commit_on: got %b want 0000", bus.voice_on); end
    step();
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.voice_active !== 4'b0000) begin n_bad++; $display("FAIL abort_commit_active: got %b want 0000", bus.voice_active); end
  endtask

  task automatic test_saturate();
    do_reset();
    issue_full(ON, 7'd1, 23'd1);
    issue_full(ON, 7'd2, 23'd2);
    issue_full(ON, 7'd3, 23'd3);
    issue_full(ON, 7'd4, 23'd4);
    for (int i = 0; i < 300; i++) begin
      issue_full(ON, 7'(10 + (i % 100)), 23'(i + 1));
      if (i == 99) begin
        n_cmp++; if (bus.steal_cnt !== 8'd100) begin n_bad++; $display("FAIL steal_cnt_100: got %0d want 100", bus.steal_cnt); end
      end
    end
    n_cmp++; if (bus.steal_cnt !== 8'd255) begin n_bad++; $display("FAIL steal_cnt_sat: got %0d want 255", bus.steal_cnt); end
    n_cmp++; if (bus.voice_active !== 4'b1111) begin n_bad++; $display("FAIL sat_active: got %b want 1111", bus.voice_active); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    test_reset();
    test_first_note();
    test_steal();
    test_retrigger();
    test_all_off();
    test_zero_period();
    test_abort();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
